i2s_transmitter: RTL
====================

# i2s_transmitter

Serialises 24-bit stereo sample pairs onto an I2S data line and generates the matching word-select (lrclk) from the bit clock. It is the transmit counterpart of `receive_data_from_i2s`: it drives the same bclk/lrclk/data signalling toward a codec DAC, or loops back into the receiver for test. A one-pair holding register decouples the upstream producer from frame timing through a valid/ready handshake.

## Interface

Parameters:
- `sdsize`, 24: sample width in bits.
- `countsize`, 32: bclk cycles per channel slot; must satisfy countsize >= sdsize+1.

Ports:
- `bclk`  in  1  bit clock; the block's only clock. All state updates on the falling edge of bclk.
- `rst`  in  1  reset, synchronous, active-high.
- `left_data`  in  sdsize  left sample, two's complement.
- `right_data`  in  sdsize  right sample, two's complement.
- `data_valid`  in  1  producer has a pair on left_data/right_data.
- `data_ready`  out  1  holding register empty; pair accepted on an edge where data_valid && data_ready.
- `lrclk`  out  1  word select, registered; 0 = left slot, 1 = right slot.
- `i2s_din`  out  1  serial data, registered, MSB first.
- `underrun`  out  1  one-cycle pulse, frame started with no pair held.

## Operation

- Slot counter `k` runs 0..countsize-1 and increments each edge. lrclk toggles on the edge where k wraps from countsize-1 to 0. A frame is 2*countsize edges: left slot, then right slot.
- Bit placement per slot:
  - At k = 0, i2s_din = 0. This is the standard I2S one-bit delay after an lrclk transition.
  - At k = 1..sdsize, i2s_din carries sample bit sdsize-k, MSB at k=1.
  - At k > sdsize, i2s_din = 0 (zero padding).
- Holding register:
  - Holds one pair plus a `full` flag. data_ready = !full && !rst.
  - A handshake sets full and captures both samples.
- Frame load:
  - Happens on the edge where lrclk goes 1->0, i.e. left slot, k becomes 0.
  - If full: copy the held pair into the left and right shift registers and clear full. data_ready rises on the next edge.
  - If not full: load zeros into both shift registers and pulse underrun for exactly that edge.
- Simultaneous events:
  - A handshake on the load edge cannot occur while full, because ready is low.
  - If empty, a handshake on the load edge fills the holding register, but the frame still underruns. There is no bypass; that pair goes out in the next frame.
- Reset clears:
  - k = countsize-1, lrclk = 1, i2s_din = 0, underrun = 0, full = 0, shift registers = 0.
  - data_ready is 0 while rst is high.
- Reset mid-frame aborts the frame immediately and discards any held pair. There is no partial-frame completion.

## Timing

- Edge E0 is the first falling edge with rst sampled low:
  - E0: k=0, lrclk=0, frame load (underrun if nothing was accepted).
  - E0+1: left MSB on i2s_din.
  - E0+countsize: lrclk=1.
  - E0+countsize+1: right MSB.
  - E0+2*countsize: next frame load.
- Handshake-to-first-bit latency ranges from 2 edges (pair accepted on the edge before a load) to 2*countsize+1 edges.
- Sustained throughput is one pair per 2*countsize edges.
- data_ready stays low from acceptance until the edge after the next frame load.
- lrclk and i2s_din both change only on falling bclk edges, so the receiver samples them stable on the rising edge.

## Test plan

- Reset, then accept left=0xA5A5A5, right=0x5A5A5A before E0. Require:
  - left slot bits k=1..24 = 1010_0101… and right slot bits = 0101_1010…
  - k=0 and k=25..31 = 0.
  - lrclk low for 32 edges, then high for 32.
- No data_valid after reset. Require underrun pulse at E0 and at every frame load, i2s_din constantly 0, lrclk still toggling every 32 edges.
- Hold data_valid high with an incrementing pair. Require:
  - exactly one acceptance per 64 edges.
  - data_ready low from each acceptance until one edge after the load.
  - no underrun; the serial output matches the accepted sequence in order.
- With the holding register empty, present data_valid exactly on a load edge. Require underrun on that frame and the pair transmitted in the following frame.
- Assert rst for one edge mid-left-slot (k=10) while full. Require:
  - the next edge shows i2s_din=0, lrclk=1, data_ready=0, and the held pair is discarded.
  - on release, the E0 sequence restarts.
- Loopback into receive_data_from_i2s with a sequence of 16 random pairs. Require every received sample to equal the transmitted one.

Source files
------------

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S serialiser for stereo sample pairs with a one-pair holding register
// All state advances on the falling edge of bclk so lrclk/i2s_din are stable at the rising edge.
module i2s_transmitter #(
  parameter int sdsize    = 24,
  parameter int countsize = 32
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic [sdsize-1:0] left_data,
  input  logic [sdsize-1:0] right_data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              lrclk,
  output logic              i2s_din,
  output logic              underrun
);

  localparam int            KW         = (countsize > 1) ? $clog2(countsize) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(countsize - 1);
  localparam logic [KW-1:0] K_DATA_END = KW'(sdsize);

  logic [KW-1:0]     k_q, k_d;
  logic              lrclk_q, lrclk_d;
  logic              din_q, din_d;
  logic              underrun_q, underrun_d;
  logic              full_q, full_d;
  logic [sdsize-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [sdsize-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic              wrap, load, accept;

  assign data_ready = !full_q && !rst;
  assign lrclk      = lrclk_q;
  assign i2s_din    = din_q;
  assign underrun   = underrun_q;

  always_comb begin
    wrap       = (k_q == K_LAST);
    load       = wrap && lrclk_q;
    accept     = data_valid && data_ready;
    k_d        = wrap ? '0 : k_q + KW'(1);
    lrclk_d    = wrap ? ~lrclk_q : lrclk_q;
    din_d      = 1'b0;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;

    if (load) begin
      if (full_q) begin
        sh_l_d = hold_l_q;
        sh_r_d = hold_r_q;
        full_d = 1'b0;
      end else begin
        sh_l_d     = '0;
        sh_r_d     = '0;
        underrun_d = 1'b1;
      end
    end else if (k_d != '0 && k_d <= K_DATA_END) begin
      // Slot k=0 is the one-bit delay; data bits follow MSB first, zero padding after.
      if (lrclk_d) begin
        din_d  = sh_r_q[sdsize-1];
        sh_r_d = {sh_r_q[sdsize-2:0], 1'b0};
      end else begin
        din_d  = sh_l_q[sdsize-1];
        sh_l_d = {sh_l_q[sdsize-2:0], 1'b0};
      end
    end

    // Accept cannot coincide with a full-register load because ready is low then.
    if (accept) begin
      full_d   = 1'b1;
      hold_l_d = left_data;
      hold_r_d = right_data;
    end
  end

  always_ff @(negedge bclk) begin
    if (rst) begin
      k_q        <= K_LAST;
      lrclk_q    <= 1'b1;
      din_q      <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
    end else begin
      k_q        <= k_d;
      lrclk_q    <= lrclk_d;
      din_q      <= din_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
    end
  end

endmodule
